// File: rtl/mont_pow_ctrl_if.sv
// Start/done handshake between the exponentiation sequencer (master) and
// one bit-serial Montgomery multiplier (slave).
interface mont_pow_ctrl_if #(
  parameter int WIDTH = 260
);
  logic             mul_start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_m;
  logic [WIDTH-1:0] mul_result;
  logic             mul_done;

  modport master (
    output mul_start, mul_a, mul_b, mul_m,
    input  mul_result, mul_done
  );

  modport slave (
    input  mul_start, mul_a, mul_b, mul_m,
    output mul_result, mul_done
  );
endinterface

// File: rtl/mont_pow_ctrl.sv
// Modular-exponentiation sequencer: right-to-left square-and-multiply in the
// Montgomery domain, driving an external multiplier through the handshake.
module mont_pow_ctrl #(
  parameter int WIDTH = 260,
  parameter int EBITS = 256,
  parameter int MBITS = 256,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic [CW-1:0]    mul_count,
  mont_pow_ctrl_if.master  mul
);

  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] TO_MONT_X   = 4'd1;
  localparam logic [3:0] TO_MONT_ACC = 4'd2;
  localparam logic [3:0] LOOP        = 4'd3;
  localparam logic [3:0] SHIFT       = 4'd4;
  localparam logic [3:0] FROM_MONT   = 4'd5;
  localparam logic [3:0] FINISH      = 4'd6;
  localparam logic [3:0] ISSUE       = 4'd7;
  localparam logic [3:0] WAIT_LO     = 4'd8;
  localparam logic [3:0] WAIT_HI     = 4'd9;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  if (WIDTH < MBITS + 2) begin : g_width_check
    $error("mont_pow_ctrl: WIDTH must leave headroom above MBITS");
  end

  logic [3:0]       state;
  logic [3:0]       ret_state;
  logic             dest_acc;
  logic [WIDTH-1:0] base_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] r2_reg;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [EBITS-1:0] e_reg;

  logic             launch;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_dest;
  logic [3:0]       op_ret;

  // Every product step funnels through here: which operands, where the
  // result lands, and which state resumes once the multiplier is done.
  always_comb begin
    launch  = 1'b0;
    op_a    = x_reg;
    op_b    = x_reg;
    op_dest = 1'b0;
    op_ret  = LOOP;
    case (state)
      TO_MONT_X: begin
        launch = 1'b1;
        op_a   = base_reg;
        op_b   = r2_reg;
        op_ret = TO_MONT_ACC;
      end
      TO_MONT_ACC: begin
        launch  = 1'b1;
        op_a    = ONE;
        op_b    = r2_reg;
        op_dest = 1'b1;
      end
      LOOP: begin
        launch  = (e_reg != '0) && e_reg[0];
        op_a    = acc_reg;
        op_dest = 1'b1;
        op_ret  = SHIFT;
      end
      SHIFT: begin
        launch = (e_reg[EBITS-1:1] != '0);
      end
      FROM_MONT: begin
        launch  = 1'b1;
        op_a    = acc_reg;
        op_b    = ONE;
        op_dest = 1'b1;
        op_ret  = FINISH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ret_state     <= IDLE;
      dest_acc      <= 1'b0;
      base_reg      <= '0;
      m_reg         <= '0;
      r2_reg        <= '0;
      x_reg         <= '0;
      acc_reg       <= '0;
      e_reg         <= '0;
      result        <= '0;
      done          <= 1'b0;
      mul_count     <= '0;
      mul.mul_start <= 1'b0;
      mul.mul_a     <= '0;
      mul.mul_b     <= '0;
      mul.mul_m     <= '0;
    end else begin
      mul.mul_start <= 1'b0;
      case (state)
        IDLE: begin
          done <= ~start;
          if (start) begin
            base_reg  <= base;
            e_reg     <= exp;
            m_reg     <= m;
            r2_reg    <= r2;
            mul_count <= '0;
            state     <= TO_MONT_X;
          end
        end
        TO_MONT_X, TO_MONT_ACC, FROM_MONT: ;
        LOOP: state <= (e_reg == '0) ? FROM_MONT : SHIFT;
        SHIFT: begin
          e_reg <= e_reg >> 1;
          state <= LOOP;
        end
        ISSUE: state <= WAIT_LO;
        WAIT_LO: if (!mul.mul_done) state <= WAIT_HI;
        WAIT_HI: begin
          if (mul.mul_done) begin
            if (dest_acc) acc_reg <= mul.mul_result;
            else          x_reg   <= mul.mul_result;
            state <= ret_state;
          end
        end
        FINISH: begin
          result <= acc_reg;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A launch overrides the state transition above and parks in ISSUE.
      if (launch) begin
        mul.mul_a     <= op_a;
        mul.mul_b     <= op_b;
        mul.mul_m     <= m_reg;
        mul.mul_start <= 1'b1;
        if (mul_count != '1) mul_count <= mul_count + CW'(1);
        dest_acc      <= op_dest;
        ret_state     <= op_ret;
        state         <= ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_mont_pow_ctrl.sv
// Self-checking bench: behavioural Montgomery multiplier stub with random
// latency, golden modular power by plain wide arithmetic.
module tb_mont_pow_ctrl;
  localparam int WIDTH = 260;
  localparam int EBITS = 256;
  localparam int MBITS = 256;
  localparam int CW    = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] base;
  logic [EBITS-1:0] exp;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] r2;
  logic [WIDTH-1:0] result;
  logic             done;
  logic [CW-1:0]    mul_count;

  mont_pow_ctrl_if #(.WIDTH(WIDTH)) mul_bus ();

  mont_pow_ctrl #(.WIDTH(WIDTH), .EBITS(EBITS), .MBITS(MBITS), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .exp       (exp),
    .m         (m),
    .r2        (r2),
    .result    (result),
    .done      (done),
    .mul_count (mul_count),
    .mul       (mul_bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt   = 0;
  int stable_err  = 0;
  int dly_lo      = 0;
  int dly_hi      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Multiplier reference: x*y*2^-MBITS mod m by bit-serial reduction.
  function automatic logic [WIDTH-1:0] mont_mul(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] mm);
    logic [WIDTH+1:0] t;
    t = '0;
    for (int i = 0; i < MBITS; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, mm};
      t = t >> 1;
    end
    if (t >= {2'b00, mm}) t = t - {2'b00, mm};
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] pow_mod(input logic [WIDTH-1:0] b,
                                               input logic [EBITS-1:0] e,
                                               input logic [WIDTH-1:0] mm);
    logic [2*WIDTH-1:0] r, s, mw;
    mw = {{WIDTH{1'b0}}, mm};
    r  = 1 % mw;
    s  = {{WIDTH{1'b0}}, b} % mw;
    for (int i = 0; i < EBITS; i++) begin
      if (e[i]) r = (r * s) % mw;
      s = (s * s) % mw;
    end
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] r2_of(input logic [WIDTH-1:0] mm);
    logic [2*WIDTH-1:0] t, mw;
    mw = {{WIDTH{1'b0}}, mm};
    t  = '0;
    t[2*MBITS] = 1'b1;
    t = t % mw;
    return t[WIDTH-1:0];
  endfunction

  function automatic int exp_products(input logic [EBITS-1:0] e);
    int pc, bl;
    pc = 0;
    bl = 0;
    for (int i = 0; i < EBITS; i++) begin
      if (e[i]) begin
        pc++;
        bl = i + 1;
      end
    end
    return (bl == 0) ? 3 : 3 + pc + bl - 1;
  endfunction

  function automatic logic [255:0] rand_wide();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Multiplier stub: acknowledges one cycle after mul_start, then holds
  // mul_done low for a random number of extra cycles.
  logic             stub_done;
  logic             stub_busy;
  logic             pending;
  int               stub_cnt;
  logic [WIDTH-1:0] stub_res;
  logic [WIDTH-1:0] cap_a, cap_b, cap_m;

  assign mul_bus.mul_done   = stub_done;
  assign mul_bus.mul_result = stub_res;

  always @(posedge clk) begin
    if (reset) begin
      stub_done <= 1'b1;
      stub_busy <= 1'b0;
      pending   <= 1'b0;
      stub_cnt  <= 0;
      stub_res  <= '0;
    end else if (mul_bus.mul_start) begin
      stub_done <= 1'b0;
      stub_busy <= 1'b1;
      pending   <= 1'b1;
      cap_a     <= mul_bus.mul_a;
      cap_b     <= mul_bus.mul_b;
      cap_m     <= mul_bus.mul_m;
      stub_res  <= mont_mul(mul_bus.mul_a, mul_bus.mul_b, mul_bus.mul_m);
      stub_cnt  <= int'($urandom_range(dly_hi, dly_lo));
    end else if (stub_busy) begin
      if (stub_cnt == 0) begin
        stub_done <= 1'b1;
        stub_busy <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end else if (pending && stub_done) begin
      pending <= 1'b0;
    end
  end

  always @(posedge clk)
    if (!reset && mul_bus.mul_start) pulse_cnt++;

  always @(negedge clk)
    if (!reset && pending &&
        (mul_bus.mul_a !== cap_a || mul_bus.mul_b !== cap_b || mul_bus.mul_m !== cap_m))
      stable_err++;

  task automatic applyStimulus(input logic [WIDTH-1:0] b, input logic [EBITS-1:0] e,
                               input logic [WIDTH-1:0] mm, input logic [WIDTH-1:0] rr,
                               input bit poke);
    logic [WIDTH-1:0] want;
    int want_n, p0, s0;
    bit seen;
    want   = pow_mod(b, e, mm);
    want_n = exp_products(e);
    seen   = 1'b0;
    @(negedge clk);
    p0 = pulse_cnt;
    s0 = stable_err;
    base  = b;
    exp   = e;
    m     = mm;
    r2    = rr;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("done_fall", {{(WIDTH-1){1'b0}}, done}, '0);
    base = {4'h0, rand_wide()};
    exp  = rand_wide();
    m    = {4'h0, rand_wide()} | 1;
    r2   = {4'h0, rand_wide()};
    for (int cyc = 0; cyc < 30000 && !seen; cyc++) begin
      @(negedge clk);
      if (poke && cyc == 20) begin
        start = 1'b1;
        base  = {4'h0, rand_wide()};
        exp   = rand_wide();
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    checkOutput("finished", {{(WIDTH-1){1'b0}}, seen}, 1);
    checkOutput("result", result, want);
    checkOutput("mul_count", {{(WIDTH-CW){1'b0}}, mul_count}, WIDTH'(want_n));
    checkOutput("start_pulses", WIDTH'(pulse_cnt - p0), WIDTH'(want_n));
    checkOutput("operand_stable", WIDTH'(stable_err - s0), '0);
  endtask

  logic [WIDTH-1:0] p25519;
  logic [WIDTH-1:0] r2_big;
  logic [WIDTH-1:0] rb;
  logic [EBITS-1:0] re;

  initial begin
    bit found;
    int p0;
    reset = 1'b1;
    start = 1'b0;
    base  = '0;
    exp   = '0;
    m     = '0;
    r2    = '0;
    p25519 = (WIDTH'(1) << 255) - WIDTH'(19);
    r2_big = r2_of(p25519);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_result", result, '0);
    checkOutput("rst_done", {{(WIDTH-1){1'b0}}, done}, '0);
    checkOutput("rst_count", {{(WIDTH-CW){1'b0}}, mul_count}, '0);
    checkOutput("rst_mul_start", {{(WIDTH-1){1'b0}}, mul_bus.mul_start}, '0);
    checkOutput("rst_mul_a", mul_bus.mul_a, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_done", {{(WIDTH-1){1'b0}}, done}, 1);

    dly_lo = 0;
    dly_hi = 50;
    applyStimulus(3, 5, 13, 9, 1'b0);
    checkOutput("tp_result_9", result, 9);
    checkOutput("tp_count_7", {{(WIDTH-CW){1'b0}}, mul_count}, 7);
    applyStimulus(7, 0, 13, 9, 1'b0);
    checkOutput("tp_exp0_result", result, 1);
    checkOutput("tp_exp0_count", {{(WIDTH-CW){1'b0}}, mul_count}, 3);
    applyStimulus(0, 0, 1, 0, 1'b0);
    checkOutput("tp_m1_result", result, '0);
    applyStimulus(0, EBITS'($urandom_range(300, 1)), 13, 9, 1'b0);
    checkOutput("tp_base0_result", result, '0);
    for (int i = 0; i < 3; i++)
      applyStimulus(WIDTH'($urandom_range(12, 0)), EBITS'($urandom_range(300, 1)), 13, 9, 1'b0);

    // Second start mid-operation must be ignored.
    rb = {4'h0, rand_wide()} % p25519;
    re = EBITS'({1'b1, 31'($urandom)});
    applyStimulus(rb, re, p25519, r2_big, 1'b1);

    dly_lo = 0;
    dly_hi = 1;
    for (int s = 0; s < 20; s++) begin
      rb = {4'h0, rand_wide()} % p25519;
      re = rand_wide();
      applyStimulus(rb, re, p25519, r2_big, 1'b0);
    end

    // Reset while the 4th product is waiting for mul_done.
    dly_lo = 5;
    dly_hi = 5;
    @(negedge clk);
    p0    = pulse_cnt;
    base  = 3;
    exp   = 5;
    m     = 13;
    r2    = 9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
      @(negedge clk);
      if (mul_bus.mul_start && pulse_cnt - p0 == 3) found = 1'b1;
    end
    checkOutput("reach_4th_product", {{(WIDTH-1){1'b0}}, found}, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_result", result, '0);
    checkOutput("midrst_done", {{(WIDTH-1){1'b0}}, done}, '0);
    checkOutput("midrst_count", {{(WIDTH-CW){1'b0}}, mul_count}, '0);
    checkOutput("midrst_mul_start", {{(WIDTH-1){1'b0}}, mul_bus.mul_start}, '0);
    checkOutput("midrst_mul_a", mul_bus.mul_a, '0);
    checkOutput("midrst_mul_b", mul_bus.mul_b, '0);
    checkOutput("midrst_mul_m", mul_bus.mul_m, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_idle_done", {{(WIDTH-1){1'b0}}, done}, 1);
    dly_lo = 0;
    dly_hi = 50;
    applyStimulus(3, 5, 13, 9, 1'b0);
    checkOutput("post_rst_result", result, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mont_pow_ctrl.md
Name: mont_pow_ctrl

Overview:
- Modular-exponentiation sequencer; the initiator side of the start/done Montgomery-multiplier handshake.
- Computes result = base^exp mod m by issuing a sequence of Montgomery products (x·y·2^-MBITS mod m) to an external bit-serial multiplier.
- Instantiated alongside one multiplier; owns that multiplier's start and operand inputs and consumes its done/result.

Parameters:
- WIDTH, 260, operand/result width, including headroom bits for the multiplier's intermediate sums.
- EBITS, 256, exponent width scanned.
- MBITS, 256, Montgomery radix exponent (R = 2^MBITS); must match the multiplier's iteration count.
- CW, 16, width of mul_count.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request pulse; sampled in IDLE only
- base  in  WIDTH  base; bench guarantees base < m
- exp  in  EBITS  exponent
- m  in  WIDTH  odd modulus, m < 2^MBITS
- r2  in  WIDTH  precomputed R^2 mod m
- result  out  WIDTH  base^exp mod m; valid while done=1
- done  out  1  high when idle and result valid
- mul_count  out  CW  Montgomery products issued for the last/current operation
- mul_start  out  1  one-cycle request to multiplier
- mul_a, mul_b, mul_m  out  WIDTH  multiplier operands; held stable from mul_start until capture
- mul_result  in  WIDTH  multiplier output
- mul_done  in  1  multiplier idle/result-valid flag

Behaviour:
- Reset (sync): result=0, done=0, mul_count=0, mul_start=0, mul_a/b/m=0, all internal registers 0, state=IDLE.
  - Applies mid-operation: any in-flight product is abandoned and mul_start is 0 the next cycle.
- IDLE
  - done <= ~start.
  - On start=1: latch base, exp, m, r2 into internal registers; clear mul_count; state -> TO_MONT_X.
  - Input changes after the latch cycle have no effect.
- Product subroutine MUL(a, b, dest); every product step uses it:
  - ISSUE: drive mul_a=a, mul_b=b, mul_m=m_reg; mul_start <= 1 for exactly one cycle; mul_count += 1 (saturating at all-ones).
  - WAIT_LO: hold operands; wait for mul_done=0 (multiplier acknowledges within 1 cycle).
  - WAIT_HI: wait for mul_done=1; that cycle dest <= mul_result[WIDTH-1:0]; continue to the caller's next state.
  - mul_done is never sampled in the ISSUE cycle. No timeout.
- Sequence
  - TO_MONT_X: MUL(base, r2, x).
  - TO_MONT_ACC: MUL(1, r2, acc), giving acc = R mod m.
  - LOOP (e = latched exponent)
    - If e==0: -> FROM_MONT.
    - Else, if e[0]: MUL(acc, x, acc).
    - Then e <= e>>1. If the shifted e != 0: MUL(x, x, x); otherwise skip the squaring.
    - Return to LOOP.
  - FROM_MONT: MUL(acc, 1, acc).
  - FINISH: result <= acc; done <= 1; -> IDLE.
- Product count: 3 + popcount(exp) + (bitlength(exp) - 1) for exp > 0; exactly 3 for exp = 0.
- Boundary results:
  - exp=0: result = 1 mod m, i.e. 1 (0 when m=1).
  - base=0, exp>0: result = 0.
- start while busy: ignored; no queuing.
- done falls the cycle after start is sampled and rises in the cycle result updates.
- All arithmetic is done by the multiplier; the controller has no adders except mul_count.

Test Plan:
- m=13, r2=9, base=3, exp=5 -> result=9, mul_count=7, done rises, with exactly 7 single-cycle mul_start pulses.
- m=13, r2=9, base=7, exp=0 -> result=1, mul_count=3; m=1, r2=0, exp=0 -> result=0.
- m = 2^255-19, r2 from bench model, random base<m and full 256-bit exp -> result equals golden pow(base, exp, m); mul_count matches the formula. Run 20 seeds.
- Multiplier stub delaying mul_done by 0-50 random cycles; operands are checked stable from the ISSUE cycle through capture, and result stays correct.
- start pulsed again mid-operation -> ignored; result and mul_count reflect only the first request.
- reset asserted in WAIT_HI of the 4th product -> next cycle: all outputs 0, mul_start=0, state IDLE; a fresh start then completes correctly.
